// File: rtl/uart_tx_arbiter.sv
//==============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Round-robin, message-granular sharing of one uart_tx among N_REQ
//            byte-stream requesters, with gap-timeout abort of stalled owners.
// Revision : 1.0
//==============================================================================
`default_nettype none

module uart_tx_arbiter #(
   parameter int N_REQ   = 4,
   parameter int MAX_GAP = 4096
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic [N_REQ-1:0]   i_req_valid,
   input  logic [8*N_REQ-1:0] i_req_data,
   input  logic [N_REQ-1:0]   i_req_last,
   output logic [N_REQ-1:0]   o_req_ready,
   output logic [7:0]         o_tx_data,
   output logic               o_tx_start,
   input  logic               i_tx_busy,
   output logic [N_REQ-1:0]   o_grant,
   output logic               o_abort
);

   localparam int PW = $clog2(N_REQ);
   localparam int IW = PW + 1;
   localparam int GW = ($clog2(MAX_GAP + 1) > 12) ? $clog2(MAX_GAP + 1) : 12;
   localparam logic [GW-1:0] C_GAP_LIMIT = GW'(MAX_GAP - 1);

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD      = 3'd1,
      S_START     = 3'd2,
      S_WAIT_BUSY = 3'd3,
      S_WAIT_DONE = 3'd4
   } state_t;

   state_t           r_state;
   logic [PW-1:0]    r_ptr;
   logic [PW-1:0]    r_gidx;
   logic [GW-1:0]    r_gap;
   logic             r_last;
   logic [N_REQ-1:0] r_grant;
   logic [7:0]       r_tx_data;
   logic             r_tx_start;
   logic             r_abort;

   logic             w_found;
   logic [PW-1:0]    w_pick;
   logic [IW-1:0]    w_idx;
   logic [PW-1:0]    w_gnext;
   logic             w_gvalid;

   // Round-robin scan: first valid requester at or after the pointer, modulo N_REQ.
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_idx   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         w_idx = {1'b0, r_ptr} + IW'(i);
         if (w_idx >= IW'(N_REQ)) begin
            w_idx = w_idx - IW'(N_REQ);
         end
         if (!w_found && i_req_valid[w_idx[PW-1:0]]) begin
            w_found = 1'b1;
            w_pick  = w_idx[PW-1:0];
         end
      end
   end

   always_comb begin
      w_gnext     = (r_gidx == PW'(N_REQ - 1)) ? '0 : r_gidx + PW'(1);
      w_gvalid    = i_req_valid[r_gidx];
      o_req_ready = (r_state == S_LOAD) ? (r_grant & i_req_valid) : '0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state    <= S_IDLE;
         r_ptr      <= '0;
         r_gidx     <= '0;
         r_gap      <= '0;
         r_last     <= 1'b0;
         r_grant    <= '0;
         r_tx_data  <= '0;
         r_tx_start <= 1'b0;
         r_abort    <= 1'b0;
      end else begin
         r_tx_start <= 1'b0;
         r_abort    <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_gidx  <= w_pick;
                  r_grant <= N_REQ'(1) << w_pick;
                  r_gap   <= '0;
                  r_state <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (w_gvalid) begin
                  r_tx_data <= i_req_data[{r_gidx, 3'b000} +: 8];
                  r_last    <= i_req_last[r_gidx];
                  r_gap     <= '0;
                  r_state   <= S_START;
               end else if (r_gap >= C_GAP_LIMIT) begin
                  r_abort <= 1'b1;
                  r_grant <= '0;
                  r_ptr   <= w_gnext;
                  r_state <= S_IDLE;
               end else if (r_gap != '1) begin
                  r_gap <= r_gap + 1'b1;
               end
            end
            S_START: begin
               // Hold off while the UART is still shifting out an earlier frame.
               if (!i_tx_busy) begin
                  r_tx_start <= 1'b1;
                  r_state    <= S_WAIT_BUSY;
               end
            end
            S_WAIT_BUSY: begin
               if (i_tx_busy) begin
                  r_state <= S_WAIT_DONE;
               end
            end
            S_WAIT_DONE: begin
               if (!i_tx_busy) begin
                  if (r_last) begin
                     r_grant <= '0;
                     r_ptr   <= w_gnext;
                     r_state <= S_IDLE;
                  end else begin
                     r_state <= S_LOAD;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign o_tx_data  = r_tx_data;
   assign o_tx_start = r_tx_start;
   assign o_grant    = r_grant;
   assign o_abort    = r_abort;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
//==============================================================================
// Module   : tb_uart_tx_arbiter
// Purpose  : Scoreboard bench for uart_tx_arbiter with requester and uart_tx models.
// Revision : 1.0
//==============================================================================
`default_nettype none

module tb_uart_tx_arbiter;

   localparam int N        = 4;
   localparam int GAP      = 16;
   localparam int BUSY_CYC = 6;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]   req_last;
   logic [N-1:0]   req_ready;
   logic [7:0]     tx_data;
   logic           tx_start;
   logic [N-1:0]   grant;
   logic           abort;
   logic           m_busy;
   logic           x_busy;
   logic           tx_busy;
   logic [N-1:0]   took;

   assign tx_busy = m_busy | x_busy;

   logic [8:0]  rq [N][$];
   logic [11:0] exp_q [$];

   int n_cmp    = 0;
   int n_fail   = 0;
   int n_starts = 0;

   uart_tx_arbiter #(.N_REQ(N), .MAX_GAP(GAP)) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_req_valid (req_valid),
      .i_req_data  (req_data),
      .i_req_last  (req_last),
      .o_req_ready (req_ready),
      .o_tx_data   (tx_data),
      .o_tx_start  (tx_start),
      .i_tx_busy   (tx_busy),
      .o_grant     (grant),
      .o_abort     (abort)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic fail_to(input string name);
      n_cmp++;
      n_fail++;
      $display("FAIL %s: timed out, expected event never occurred", name);
   endtask

   task automatic add_byte(input int k, input logic [7:0] d, input logic l);
      rq[k].push_back({l, d});
   endtask

   task automatic exp_byte(input int k, input logic [7:0] d);
      exp_q.push_back({4'(1 << k), d});
   endtask

   function automatic bit rq_empty();
      for (int k = 0; k < N; k++) begin
         if (rq[k].size() != 0) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic wait_idle(input string name);
      int n;
      bit done;
      n    = 0;
      done = 1'b0;
      while (!done && n < 400) begin
         @(negedge clk);
         n++;
         done = (exp_q.size() == 0) && rq_empty() && (grant == '0) && !tx_busy;
      end
      if (!done) fail_to(name);
      else check(name, 32'(grant), 0);
   endtask

   task automatic wait_busy(input logic lvl, input string name);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #2;
         n++;
      end while (m_busy !== lvl && n < 100);
      if (m_busy !== lvl) fail_to(name);
   endtask

   task automatic wait_start(input int base, input string name);
      int n;
      n = 0;
      while (n_starts == base && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n_starts == base) fail_to(name);
   endtask

   // Requester model: presents the head of each queue, pops it on the edge it is consumed.
   initial begin : requesters
      logic [8:0] h;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      forever begin
         @(negedge clk);
         took = req_ready & req_valid;
         @(posedge clk);
         #1;
         for (int k = 0; k < N; k++) begin
            if (took[k] && rq[k].size() > 0) void'(rq[k].pop_front());
            if (rq[k].size() > 0) begin
               h                 = rq[k][0];
               req_valid[k]      = 1'b1;
               req_data[8*k +: 8] = h[7:0];
               req_last[k]       = h[8];
            end else begin
               req_valid[k] = 1'b0;
               req_last[k]  = 1'b0;
            end
         end
      end
   end

   // uart_tx model: busy rises the cycle after the start pulse and lasts BUSY_CYC cycles.
   initial begin : uart_model
      m_busy = 1'b0;
      forever begin
         @(negedge clk);
         if (tx_start && rst_n) begin
            @(posedge clk);
            #1 m_busy = 1'b1;
            repeat (BUSY_CYC) @(posedge clk);
            #1 m_busy = 1'b0;
         end
      end
   end

   initial begin : monitor
      logic        prev_start;
      logic [11:0] e;
      prev_start = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_start = 1'b0;
         end else begin
            if (tx_start) begin
               n_starts++;
               check("start_single_cycle", 32'(prev_start), 0);
               if (exp_q.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL unexpected_start: got byte 0x%0h grant 0x%0h, expected no transfer",
                           tx_data, grant);
               end else begin
                  e = exp_q.pop_front();
                  check("tx_data", 32'(tx_data), 32'(e[7:0]));
                  check("grant_at_start", 32'(grant), 32'(e[11:8]));
               end
            end
            if (req_ready != '0) check("ready_only_granted", 32'(req_ready & ~grant), 0);
            prev_start = tx_start;
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin : stimulus
      int base;
      int cnt;
      bit seen;
      rst_n  = 1'b0;
      x_busy = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_grant", 32'(grant), 0);
      check("rst_start", 32'(tx_start), 0);
      check("rst_abort", 32'(abort), 0);
      check("rst_ready", 32'(req_ready), 0);
      check("rst_data", 32'(tx_data), 0);
      rst_n = 1'b1;

      // 1: "Hi\r\n" from requester 0
      add_byte(0, 8'h48, 1'b0); add_byte(0, 8'h69, 1'b0);
      add_byte(0, 8'h0D, 1'b0); add_byte(0, 8'h0A, 1'b1);
      exp_byte(0, 8'h48); exp_byte(0, 8'h69); exp_byte(0, 8'h0D); exp_byte(0, 8'h0A);
      base = n_starts;
      wait_idle("t1_idle");
      check("t1_pulses", n_starts - base, 4);

      // 2: all four requesters at once with pointer at 0
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < N; k++) begin
         add_byte(k, 8'(8'h10 * (k + 1)), 1'b0);
         add_byte(k, 8'(8'h10 * (k + 1) + 1), 1'b1);
         exp_byte(k, 8'(8'h10 * (k + 1)));
         exp_byte(k, 8'(8'h10 * (k + 1) + 1));
      end
      wait_idle("t2_idle");

      // 3: move pointer to 2, then requesters 1 and 3 compete -> 3,1,3,1
      add_byte(1, 8'h78, 1'b1); exp_byte(1, 8'h78);
      wait_idle("t3_setup_idle");
      add_byte(1, 8'h61, 1'b1); add_byte(1, 8'h62, 1'b1);
      add_byte(3, 8'h63, 1'b1); add_byte(3, 8'h64, 1'b1);
      exp_byte(3, 8'h63); exp_byte(1, 8'h61); exp_byte(3, 8'h64); exp_byte(1, 8'h62);
      wait_idle("t3_idle");

      // 4: requester 2 stalls after a non-final byte
      add_byte(2, 8'h5A, 1'b0); exp_byte(2, 8'h5A);
      base = n_starts;
      wait_start(base, "t4_start");
      wait_busy(1'b1, "t4_busy_rise");
      wait_busy(1'b0, "t4_busy_fall");
      cnt  = 0;
      seen = 1'b0;
      while (!seen && cnt < 40) begin
         @(negedge clk);
         cnt++;
         seen = abort;
      end
      if (!seen) begin
         fail_to("t4_abort");
      end else begin
         // 1 cycle to observe busy low, 16 LOAD cycles, then the registered pulse
         check("t4_abort_cycle", cnt, 18);
         check("t4_grant_on_abort", 32'(grant), 0);
         @(negedge clk);
         check("t4_abort_one_cycle", 32'(abort), 0);
      end
      add_byte(0, 8'h30, 1'b1); add_byte(3, 8'h33, 1'b1);
      exp_byte(3, 8'h33); exp_byte(0, 8'h30);
      wait_idle("t4_idle");

      // 5: UART busy held externally while the arbiter waits to start
      x_busy = 1'b1;
      add_byte(1, 8'h42, 1'b1); exp_byte(1, 8'h42);
      base = n_starts;
      repeat (10) @(negedge clk);
      check("t5_no_start_while_busy", n_starts - base, 0);
      x_busy = 1'b0;
      wait_idle("t5_idle");
      check("t5_one_pulse", n_starts - base, 1);

      // 6: reset during WAIT_DONE
      add_byte(0, 8'h41, 1'b0); add_byte(0, 8'h43, 1'b1);
      exp_byte(0, 8'h41);
      base = n_starts;
      wait_start(base, "t6_start");
      wait_busy(1'b1, "t6_busy_rise");
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("t6_grant", 32'(grant), 0);
      check("t6_data", 32'(tx_data), 0);
      check("t6_start", 32'(tx_start), 0);
      check("t6_abort", 32'(abort), 0);
      check("t6_ready", 32'(req_ready), 0);
      for (int k = 0; k < N; k++) rq[k].delete();
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      add_byte(1, 8'h5A, 1'b1); exp_byte(1, 8'h5A);
      wait_idle("t6_idle");
      check("scoreboard_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
